data_memory_port: RTL and testbench

DATA_MEMORY_PORT -- requirements
Module: data_memory_port

---
 rtl/memory_pkg.sv | 17 +
 rtl/address_check.sv | 14 +
 rtl/data_memory_port.sv | 130 +++++++++++++
 tb/tb_data_memory_port.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared types and constants for the data memory port
package memory_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  localparam int unsigned WORD_IDX_W = 8;
  localparam int unsigned BYTE_OFF_W = 3;

  // Offset bits that must be zero for an in-range, word-aligned access
  localparam logic [63:0] ALIGN_MASK = 64'h0000_0000_0000_0007;
  localparam logic [63:0] RANGE_MASK = 64'hFFFF_FFFF_FFFF_F800;

endpackage

// File: rtl/address_check.sv
// rtl/address_check.sv - alignment and range check of a RAM byte offset
module address_check
  import memory_pkg::*;
(
  input  logic [63:0]           offset_i,
  output logic                  error_o,
  output logic [WORD_IDX_W-1:0] word_index_o
);

  // Misaligned if any byte-lane bit is set, out of range if any bit above the RAM span is set
  assign error_o      = (|(offset_i & ALIGN_MASK)) | (|(offset_i & RANGE_MASK));
  assign word_index_o = offset_i[BYTE_OFF_W +: WORD_IDX_W];

endmodule

// File: rtl/data_memory_port.sv
// rtl/data_memory_port.sv - serialized request/response port to an external 256x64 RAM
module data_memory_port
  import memory_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned WORDS     = 256
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [63:0]           req_address,
  input  logic [63:0]           req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [63:0]           resp_data,
  output logic                  resp_error,
  output logic [WORD_IDX_W-1:0] ram_address,
  output logic [63:0]           ram_in,
  output logic                  ram_write,
  input  logic [63:0]           ram_out,
  output logic [15:0]           load_count,
  output logic [15:0]           store_count
);

  // The word index width is fixed by the package; any other depth is a build error
  if (WORDS != (1 << WORD_IDX_W)) begin : g_words_check
    $error("data_memory_port: WORDS must equal 2**WORD_IDX_W");
  end

  state_e state_q, state_d;

  logic                  write_q;
  logic [63:0]           data_q;
  logic [63:0]           offset_q;
  logic [63:0]           resp_data_q;
  logic                  resp_error_q;
  logic [15:0]           load_count_q;
  logic [15:0]           store_count_q;
  logic                  addr_error;
  logic [WORD_IDX_W-1:0] word_index;

  address_check u_address_check (
    .offset_i     (offset_q),
    .error_o      (addr_error),
    .word_index_o (word_index)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake/RAM strobes; ram_write clears asynchronously with the state
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    ram_write  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        ram_write = write_q & ~addr_error;
        state_d   = RESPOND;
      end
      RESPOND: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, response registration and completion counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_q       <= 1'b0;
      data_q        <= 64'h0;
      offset_q      <= 64'h0;
      resp_data_q   <= 64'h0;
      resp_error_q  <= 1'b0;
      load_count_q  <= 16'h0;
      store_count_q <= 16'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            data_q   <= req_data;
            offset_q <= req_address - BASE_ADDR;
          end
        end
        ACCESS: begin
          resp_data_q  <= (!write_q && !addr_error) ? ram_out : 64'h0;
          resp_error_q <= addr_error;
        end
        RESPOND: begin
          if (resp_ready && !resp_error_q) begin
            if (write_q) begin
              store_count_q <= store_count_q + 16'd1;
            end else begin
              load_count_q <= load_count_q + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_address = word_index;
  assign ram_in      = data_q;
  assign resp_data   = resp_data_q;
  assign resp_error  = resp_error_q;
  assign load_count  = load_count_q;
  assign store_count = store_count_q;

endmodule

// File: tb/tb_data_memory_port.sv
// tb/tb_data_memory_port.sv - self-checking bench for data_memory_port
module tb_data_memory_port;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [63:0] req_address = 64'h0;
  logic [63:0] req_data = 64'h0;
  logic        resp_ready = 1'b0;
  bit          sel = 1'b0;

  logic        req_ready0, resp_valid0, resp_error0, ram_write0;
  logic [63:0] resp_data0, ram_in0;
  logic [63:0] ram_out0 = 64'h0;
  logic [7:0]  ram_address0;
  logic [15:0] load_count0, store_count0;

  logic        req_ready1, resp_valid1, resp_error1, ram_write1;
  logic [63:0] resp_data1, ram_in1;
  logic [63:0] ram_out1 = 64'h0;
  logic [7:0]  ram_address1;
  logic [15:0] load_count1, store_count1;

  logic [63:0] mem0 [256] = '{default: 64'h0};
  logic [63:0] mem1 [256] = '{default: 64'h0};
  int          wr_cnt [2] = '{0, 0};

  logic        r_req_ready, r_resp_valid, r_resp_error, r_ram_write;
  logic [63:0] r_resp_data, r_ram_in;
  logic [7:0]  r_ram_address;
  logic [15:0] r_load_count, r_store_count;

  logic [63:0] ref_mem [2][256] = '{default: '{default: 64'h0}};
  logic [15:0] ref_ld [2] = '{16'h0, 16'h0};
  logic [15:0] ref_st [2] = '{16'h0, 16'h0};
  logic [63:0] base [2] = '{64'h0, 64'h1000};

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  data_memory_port #(.BASE_ADDR(64'h0), .WORDS(256)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid & ~sel), .req_ready(req_ready0), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
    .resp_valid(resp_valid0), .resp_ready(resp_ready), .resp_data(resp_data0), .resp_error(resp_error0),
    .ram_address(ram_address0), .ram_in(ram_in0), .ram_write(ram_write0), .ram_out(ram_out0),
    .load_count(load_count0), .store_count(store_count0)
  );

  data_memory_port #(.BASE_ADDR(64'h1000), .WORDS(256)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid & sel), .req_ready(req_ready1), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
    .resp_valid(resp_valid1), .resp_ready(resp_ready), .resp_data(resp_data1), .resp_error(resp_error1),
    .ram_address(ram_address1), .ram_in(ram_in1), .ram_write(ram_write1), .ram_out(ram_out1),
    .load_count(load_count1), .store_count(store_count1)
  );

  // External RAMs: write commit and read-data register on the falling edge
  always @(negedge clock) begin
    if (ram_write0) begin
      mem0[ram_address0] <= ram_in0;
      wr_cnt[0] <= wr_cnt[0] + 1;
    end
    if (ram_write1) begin
      mem1[ram_address1] <= ram_in1;
      wr_cnt[1] <= wr_cnt[1] + 1;
    end
    ram_out0 <= mem0[ram_address0];
    ram_out1 <= mem1[ram_address1];
  end

  always_comb begin
    r_req_ready   = sel ? req_ready1   : req_ready0;
    r_resp_valid  = sel ? resp_valid1  : resp_valid0;
    r_resp_error  = sel ? resp_error1  : resp_error0;
    r_resp_data   = sel ? resp_data1   : resp_data0;
    r_ram_write   = sel ? ram_write1   : ram_write0;
    r_ram_in      = sel ? ram_in1      : ram_in0;
    r_ram_address = sel ? ram_address1 : ram_address0;
    r_load_count  = sel ? load_count1  : load_count0;
    r_store_count = sel ? store_count1 : store_count0;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One complete request through the selected port, checked against the reference model
  task automatic do_req(input bit w, input logic [63:0] a, input logic [63:0] d, input int hold);
    logic [63:0] off, exp_data;
    logic [7:0]  idx;
    bit          err, exp_wr;
    int          wr_before, waited;
    off      = a - base[sel];
    err      = (off % 64'd8 != 64'd0) || (off >= 64'd2048);
    idx      = 8'((off / 64'd8) % 64'd256);
    exp_wr   = w && !err;
    exp_data = (!w && !err) ? ref_mem[sel][idx] : 64'h0;
    waited = 0;
    while (!r_req_ready && waited < 8) begin
      @(posedge clock); #1;
      waited++;
    end
    checks++;
    if (r_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_wait: got %b want 1", r_req_ready);
    end
    wr_before   = wr_cnt[sel];
    req_valid   = 1'b1;
    req_write   = w;
    req_address = a;
    req_data    = d;
    @(posedge clock); #1;
    req_valid = 1'b0;
    checks++;
    if (r_ram_write !== exp_wr) begin
      errors++;
      $display("FAIL ram_write a=%h: got %b want %b", a, r_ram_write, exp_wr);
    end
    checks++;
    if (r_ram_address !== idx || r_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL access a=%h: got addr %0d ready %b want addr %0d ready 0", a, r_ram_address, r_req_ready, idx);
    end
    @(posedge clock); #1;
    for (int h = 0; h <= hold; h++) begin
      checks++;
      if (r_resp_valid !== 1'b1 || r_req_ready !== 1'b0 || r_resp_data !== exp_data || r_resp_error !== err) begin
        errors++;
        $display("FAIL respond a=%h cyc=%0d: got v=%b rdy=%b d=%h e=%b want v=1 rdy=0 d=%h e=%b",
                 a, h, r_resp_valid, r_req_ready, r_resp_data, r_resp_error, exp_data, err);
      end
      if (h < hold) begin
        @(posedge clock); #1;
      end
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    if (!err) begin
      if (w) begin
        ref_mem[sel][idx] = d;
        ref_st[sel]       = ref_st[sel] + 16'd1;
      end else begin
        ref_ld[sel] = ref_ld[sel] + 16'd1;
      end
    end
    checks++;
    if (r_req_ready !== 1'b1 || r_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_handshake a=%h: got rdy=%b v=%b want rdy=1 v=0", a, r_req_ready, r_resp_valid);
    end
    checks++;
    if (r_load_count !== ref_ld[sel] || r_store_count !== ref_st[sel]) begin
      errors++;
      $display("FAIL counters a=%h: got ld=%h st=%h want ld=%h st=%h", a, r_load_count, r_store_count, ref_ld[sel], ref_st[sel]);
    end
    checks++;
    if (wr_cnt[sel] - wr_before !== (exp_wr ? 1 : 0)) begin
      errors++;
      $display("FAIL write_pulses a=%h: got %0d want %0d", a, wr_cnt[sel] - wr_before, exp_wr ? 1 : 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (r_req_ready !== 1'b1 || r_resp_valid !== 1'b0 || r_resp_error !== 1'b0 || r_ram_write !== 1'b0) begin
      errors++;
      $display("FAIL %s_ctrl: got rdy=%b v=%b e=%b wr=%b want 1 0 0 0", tag, r_req_ready, r_resp_valid, r_resp_error, r_ram_write);
    end
    checks++;
    if (r_resp_data !== 64'h0 || r_ram_in !== 64'h0 || r_ram_address !== 8'h0) begin
      errors++;
      $display("FAIL %s_data: got d=%h in=%h addr=%h want 0", tag, r_resp_data, r_ram_in, r_ram_address);
    end
    checks++;
    if (r_load_count !== 16'h0 || r_store_count !== 16'h0) begin
      errors++;
      $display("FAIL %s_counts: got ld=%h st=%h want 0", tag, r_load_count, r_store_count);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sel = 1'b0;
    #1;
    check_reset_outputs("reset0");
    sel = 1'b1;
    check_reset_outputs("reset1");
    sel = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_store_load();
    sel = 1'b0;
    do_req(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 0);
    do_req(1'b0, 64'h10, 64'h0, 0);
    do_req(1'b0, 64'h13, 64'h0, 1);
    do_req(1'b1, 64'h7F8, 64'h0123_4567_89AB_CDEF, 0);
    do_req(1'b0, 64'h7F8, 64'h0, 0);
    do_req(1'b1, 64'h800, 64'h1111, 0);
  endtask

  task automatic test_base_addr();
    sel = 1'b1;
    do_req(1'b1, 64'h1800, 64'hAAAA_5555_AAAA_5555, 0);
    do_req(1'b1, 64'h17F8, 64'h5A5A_A5A5_0F0F_F0F0, 0);
    do_req(1'b0, 64'h17F8, 64'h0, 0);
    do_req(1'b0, 64'h0FF8, 64'h0, 0);
    do_req(1'b1, 64'h1000, 64'hFEED_FACE_0000_0001, 0);
    do_req(1'b0, 64'h1000, 64'h0, 0);
    sel = 1'b0;
  endtask

  task automatic test_stall();
    sel = 1'b0;
    do_req(1'b1, 64'h20, 64'hCAFE_0000_BEEF_0001, 5);
    do_req(1'b0, 64'h20, 64'h0, 5);
    do_req(1'b0, 64'h21, 64'h0, 5);
  endtask

  task automatic test_random();
    logic [63:0] a, d;
    int kind;
    sel = 1'b0;
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 5));
      if (kind <= 3)      a = {53'h0, 8'($urandom_range(0, 255)), 3'b000};
      else if (kind == 4) a = {53'h0, 8'($urandom_range(0, 255)), 3'($urandom_range(1, 7))};
      else                a = {32'($urandom), 32'($urandom)} | 64'h800;
      d = {32'($urandom), 32'($urandom)};
      do_req(1'($urandom_range(0, 1)), a, d, int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_reset_mid_store();
    sel = 1'b0;
    do_req(1'b1, 64'h40, 64'h1234_5678_9ABC_DEF0, 0);
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_address = 64'h40;
    req_data    = 64'hBAD0_BAD0_BAD0_BAD0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    checks++;
    if (r_ram_write !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: got ram_write %b want 1", r_ram_write);
    end
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clock); #1;
    checks++;
    if (mem0[8] !== 64'h1234_5678_9ABC_DEF0) begin
      errors++;
      $display("FAIL midreset_word: got %h want %h", mem0[8], 64'h1234_5678_9ABC_DEF0);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    ref_ld[0] = 16'h0;
    ref_st[0] = 16'h0;
    ref_ld[1] = 16'h0;
    ref_st[1] = 16'h0;
    do_req(1'b0, 64'h40, 64'h0, 0);
  endtask

  task automatic test_count_wrap();
    sel = 1'b0;
    @(negedge clock);
    force dut0.load_count_q = 16'hFFFD;
    #1;
    release dut0.load_count_q;
    ref_ld[0] = 16'hFFFD;
    @(posedge clock); #1;
    for (int n = 0; n < 4; n++) begin
      do_req(1'b0, 64'h10, 64'h0, 0);
    end
    do_req(1'b0, 64'h11, 64'h0, 0);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_base_addr();
    test_stall();
    test_random();
    test_reset_mid_store();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
